// File: rtl/pipe_mem_arb.sv
// Arbiter/sequencer sharing one single-port memory between the fetch stage
// and the data-memory stage. One transaction at a time, round-robin under
// contention, registered memory attributes, sticky timeout flag.
module pipe_mem_arb #(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int TMO = 64
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ack,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_ack,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          stall_if,
  output logic          stall_dm,
  output logic          err
);

  localparam int CW = $clog2(TMO) + 1;

  typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;

  state_t        state;
  state_t        state_nxt;
  logic          last_is_data;
  logic [CW-1:0] cnt;

  logic if_elig;
  logic dm_elig;
  logic busy;
  logic tmo_hit;
  logic timeout;
  logic done;

  // A request still high in the cycle its ack is shown has already been
  // served, so it must not win arbitration again in that cycle.
  assign if_elig  = if_req & ~if_ack;
  assign dm_elig  = dm_req & ~dm_ack;
  assign stall_if = if_req & ~if_ack;
  assign stall_dm = dm_req & ~dm_ack;

  // A transaction ends either on the memory ack or when the wait budget runs out.
  assign busy    = (state == FETCH) || (state == DATA);
  assign tmo_hit = (cnt == CW'(TMO - 1));
  assign timeout = busy & ~mem_ack & tmo_hit;
  assign done    = busy & (mem_ack | tmo_hit);

  // Next-state: round-robin grant in IDLE, return to IDLE on completion.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (dm_elig && (!if_elig || !last_is_data)) begin
          state_nxt = DATA;
        end else if (if_elig) begin
          state_nxt = FETCH;
        end
      end
      FETCH, DATA: begin
        if (done) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Memory attributes, wait counter, per-requester read data and ack pulses.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      last_is_data <= 1'b0;
      cnt          <= '0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      if_ack       <= 1'b0;
      dm_ack       <= 1'b0;
      if_rdata     <= '0;
      dm_rdata     <= '0;
      err          <= 1'b0;
    end else begin
      if_ack <= 1'b0;
      dm_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (state_nxt == DATA) begin
            mem_req      <= 1'b1;
            mem_we       <= dm_we;
            mem_addr     <= dm_addr;
            mem_wdata    <= dm_wdata;
            last_is_data <= 1'b1;
            cnt          <= '0;
          end else if (state_nxt == FETCH) begin
            mem_req      <= 1'b1;
            mem_we       <= 1'b0;
            mem_addr     <= if_addr;
            mem_wdata    <= '0;
            last_is_data <= 1'b0;
            cnt          <= '0;
          end
        end
        FETCH, DATA: begin
          if (done) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (timeout) begin
              err <= 1'b1;
            end
            if (state == FETCH) begin
              if_ack   <= 1'b1;
              if_rdata <= mem_ack ? mem_rdata : '0;
            end else begin
              dm_ack   <= 1'b1;
              dm_rdata <= (mem_ack && !mem_we) ? mem_rdata : '0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_mem_arb.sv
// Self-checking bench for pipe_mem_arb: directed scenarios plus randomized
// traffic checked against a word-level memory model kept in the bench.
module tb_pipe_mem_arb;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 4;

  logic          clock = 1'b0;
  logic          resetn;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ack;
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] dm_rdata;
  logic          dm_ack;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ack = 1'b0;
  logic          stall_if;
  logic          stall_dm;
  logic          err;

  int checks_total  = 0;
  int checks_passed = 0;

  // Memory responder configuration.
  int fixed_lat   = -1;
  bit never_ack   = 1'b0;
  bit inject_idle = 1'b0;
  int wait_cnt    = 0;
  int cur_lat     = 0;
  bit in_txn      = 1'b0;

  logic [31:0] mem_array [logic [31:0]];
  logic [31:0] ref_mem   [logic [31:0]];

  pipe_mem_arb #(.AW(AW), .DW(DW), .TMO(TMO)) dut (
    .clock(clock), .resetn(resetn),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall_if(stall_if), .stall_dm(stall_dm), .err(err)
  );

  always #5 clock = ~clock;

  // Power-on contents of memory; 0x100 holds the fetch-test word.
  function automatic logic [31:0] init_val(input logic [31:0] a);
    if (a == 32'h100) return 32'h2010FFFF;
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  // External memory: acks after a chosen latency, optionally never, and
  // optionally throws stray acks while no request is outstanding.
  always @(negedge clock) begin
    mem_ack = 1'b0;
    if (resetn && mem_req) begin
      if (!in_txn) begin
        in_txn   = 1'b1;
        wait_cnt = 0;
        cur_lat  = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 2));
      end
      if (!never_ack && wait_cnt >= cur_lat) begin
        mem_ack = 1'b1;
        if (mem_we) begin
          mem_array[mem_addr] = mem_wdata;
          mem_rdata = $urandom;
        end else begin
          mem_rdata = mem_array.exists(mem_addr) ? mem_array[mem_addr] : init_val(mem_addr);
        end
      end else begin
        wait_cnt++;
      end
    end else begin
      in_txn = 1'b0;
      if (inject_idle && ($urandom_range(0, 3) == 0)) begin
        mem_ack   = 1'b1;
        mem_rdata = $urandom;
      end
    end
  end

  task automatic tick;
    @(negedge clock);
  endtask

  task automatic do_reset;
    resetn      = 1'b0;
    if_req      = 1'b0;
    dm_req      = 1'b0;
    never_ack   = 1'b0;
    fixed_lat   = -1;
    inject_idle = 1'b0;
    repeat (2) tick;
    resetn = 1'b1;
  endtask

  task automatic test_reset;
    if_addr = '0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    do_reset;
    checks_total++; if (mem_req !== 1'b0) $display("[TB] FAIL reset_mem_req got=%0b exp=0", mem_req); else checks_passed++;
    checks_total++; if (mem_we !== 1'b0) $display("[TB] FAIL reset_mem_we got=%0b exp=0", mem_we); else checks_passed++;
    checks_total++; if (mem_addr !== '0) $display("[TB] FAIL reset_mem_addr got=%h exp=0", mem_addr); else checks_passed++;
    checks_total++; if (mem_wdata !== '0) $display("[TB] FAIL reset_mem_wdata got=%h exp=0", mem_wdata); else checks_passed++;
    checks_total++; if ({if_ack, dm_ack} !== 2'b00) $display("[TB] FAIL reset_acks got=%b exp=00", {if_ack, dm_ack}); else checks_passed++;
    checks_total++; if (if_rdata !== '0) $display("[TB] FAIL reset_if_rdata got=%h exp=0", if_rdata); else checks_passed++;
    checks_total++; if (dm_rdata !== '0) $display("[TB] FAIL reset_dm_rdata got=%h exp=0", dm_rdata); else checks_passed++;
    checks_total++; if (err !== 1'b0) $display("[TB] FAIL reset_err got=%0b exp=0", err); else checks_passed++;
    checks_total++; if ({stall_if, stall_dm} !== 2'b00) $display("[TB] FAIL reset_stall got=%b exp=00", {stall_if, stall_dm}); else checks_passed++;
  endtask

  task automatic test_single_fetch;
    int req_cycles;
    bit got;
    bit attr_bad;
    fixed_lat = 2;
    tick;
    if_addr = 32'h100;
    if_req  = 1'b1;
    req_cycles = 0; got = 1'b0; attr_bad = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick;
      if (if_ack) begin
        got = 1'b1;
      end else if (mem_req) begin
        req_cycles++;
        if (mem_we !== 1'b0 || mem_addr !== 32'h100) attr_bad = 1'b1;
      end
    end
    checks_total++; if (!got) $display("[TB] FAIL fetch_ack_timeout got=0 exp=1"); else checks_passed++;
    checks_total++; if (req_cycles != 3) $display("[TB] FAIL fetch_req_cycles got=%0d exp=3", req_cycles); else checks_passed++;
    checks_total++; if (attr_bad) $display("[TB] FAIL fetch_mem_attr got=bad exp=we0_addr100"); else checks_passed++;
    checks_total++; if (if_rdata !== 32'h2010FFFF) $display("[TB] FAIL fetch_rdata got=%h exp=2010ffff", if_rdata); else checks_passed++;
    checks_total++; if (stall_if !== 1'b0) $display("[TB] FAIL fetch_stall_in_ack got=%0b exp=0", stall_if); else checks_passed++;
    if_req = 1'b0;
    tick;
    checks_total++; if (if_ack !== 1'b0) $display("[TB] FAIL fetch_ack_one_cycle got=%0b exp=0", if_ack); else checks_passed++;
    checks_total++; if (if_rdata !== 32'h2010FFFF) $display("[TB] FAIL fetch_rdata_hold got=%h exp=2010ffff", if_rdata); else checks_passed++;
  endtask

  task automatic test_simultaneous;
    do_reset;
    fixed_lat = 0;
    tick;
    if_addr = 32'h300; if_req = 1'b1;
    dm_addr = 32'h200; dm_we = 1'b0; dm_req = 1'b1;
    tick;
    checks_total++; if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h200}) $display("[TB] FAIL sim_first_grant got=%b/%b/%h exp=1/0/200", mem_req, mem_we, mem_addr); else checks_passed++;
    checks_total++; if ({stall_if, stall_dm} !== 2'b11) $display("[TB] FAIL sim_stalls got=%b exp=11", {stall_if, stall_dm}); else checks_passed++;
    tick;
    checks_total++; if ({dm_ack, if_ack, mem_req} !== 3'b100) $display("[TB] FAIL sim_dm_ack got=%b exp=100", {dm_ack, if_ack, mem_req}); else checks_passed++;
    checks_total++; if (dm_rdata !== ref_read(32'h200)) $display("[TB] FAIL sim_dm_rdata got=%h exp=%h", dm_rdata, ref_read(32'h200)); else checks_passed++;
    dm_req = 1'b0;
    tick;
    checks_total++; if ({mem_req, mem_addr} !== {1'b1, 32'h300}) $display("[TB] FAIL sim_second_grant got=%b/%h exp=1/300", mem_req, mem_addr); else checks_passed++;
    tick;
    checks_total++; if (if_ack !== 1'b1) $display("[TB] FAIL sim_if_ack got=%0b exp=1", if_ack); else checks_passed++;
    checks_total++; if (if_rdata !== ref_read(32'h300)) $display("[TB] FAIL sim_if_rdata got=%h exp=%h", if_rdata, ref_read(32'h300)); else checks_passed++;
    if_req = 1'b0;
    tick;
  endtask

  task automatic test_store;
    int req_cycles;
    bit got;
    bit attr_bad;
    fixed_lat = 1;
    tick;
    dm_we = 1'b1; dm_addr = 32'h40; dm_wdata = 32'hDEADBEEF; dm_req = 1'b1;
    req_cycles = 0; got = 1'b0; attr_bad = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick;
      if (dm_ack) begin
        got = 1'b1;
      end else if (mem_req) begin
        req_cycles++;
        if (mem_we !== 1'b1 || mem_wdata !== 32'hDEADBEEF || mem_addr !== 32'h40) attr_bad = 1'b1;
      end
    end
    checks_total++; if (!got) $display("[TB] FAIL store_ack_timeout got=0 exp=1"); else checks_passed++;
    checks_total++; if (req_cycles != 2) $display("[TB] FAIL store_req_cycles got=%0d exp=2", req_cycles); else checks_passed++;
    checks_total++; if (attr_bad) $display("[TB] FAIL store_mem_attr got=unstable exp=we1_deadbeef_40"); else checks_passed++;
    checks_total++; if (dm_rdata !== 32'h0) $display("[TB] FAIL store_rdata got=%h exp=0", dm_rdata); else checks_passed++;
    ref_mem[32'h40] = 32'hDEADBEEF;
    tick;
    checks_total++; if ({dm_ack, mem_req} !== 2'b00) $display("[TB] FAIL store_no_regrant got=%b exp=00", {dm_ack, mem_req}); else checks_passed++;
    dm_req = 1'b0; dm_we = 1'b0;
    tick;
  endtask

  task automatic test_contention;
    int n;
    bit expect_dm;
    do_reset;
    inject_idle = 1'b1;
    tick;
    if_addr  = 32'h40;
    dm_addr  = 32'($urandom_range(0, 15)) << 2;
    dm_we    = 1'($urandom_range(0, 1));
    dm_wdata = $urandom;
    if_req = 1'b1; dm_req = 1'b1;
    n = 0; expect_dm = 1'b1;
    for (int c = 0; c < 100 && n < 6; c++) begin
      tick;
      if (if_ack || dm_ack) begin
        checks_total++; if ({dm_ack, if_ack} !== {expect_dm, !expect_dm}) $display("[TB] FAIL cont_order_%0d got=%b exp=%b", n, {dm_ack, if_ack}, {expect_dm, !expect_dm}); else checks_passed++;
        if (dm_ack) begin
          checks_total++; if (dm_rdata !== (dm_we ? 32'h0 : ref_read(dm_addr))) $display("[TB] FAIL cont_dm_rdata got=%h exp=%h", dm_rdata, dm_we ? 32'h0 : ref_read(dm_addr)); else checks_passed++;
          if (dm_we) ref_mem[dm_addr] = dm_wdata;
          dm_addr  = 32'($urandom_range(0, 15)) << 2;
          dm_we    = 1'($urandom_range(0, 1));
          dm_wdata = $urandom;
        end else begin
          checks_total++; if (if_rdata !== ref_read(if_addr)) $display("[TB] FAIL cont_if_rdata got=%h exp=%h", if_rdata, ref_read(if_addr)); else checks_passed++;
          if_addr = 32'($urandom_range(0, 15)) << 2;
        end
        expect_dm = !expect_dm;
        n++;
      end
    end
    checks_total++; if (n != 6) $display("[TB] FAIL cont_count got=%0d exp=6", n); else checks_passed++;
    if_req = 1'b0; dm_req = 1'b0; inject_idle = 1'b0;
    tick;
    tick;
  endtask

  task automatic test_timeout;
    int req_cycles;
    bit got;
    checks_total++; if (err !== 1'b0) $display("[TB] FAIL tmo_err_before got=%0b exp=0", err); else checks_passed++;
    never_ack = 1'b1;
    tick;
    if_addr = 32'h80; if_req = 1'b1;
    req_cycles = 0; got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick;
      if (if_ack) got = 1'b1;
      else if (mem_req) req_cycles++;
    end
    checks_total++; if (!got) $display("[TB] FAIL tmo_ack_missing got=0 exp=1"); else checks_passed++;
    checks_total++; if (req_cycles != TMO) $display("[TB] FAIL tmo_req_cycles got=%0d exp=%0d", req_cycles, TMO); else checks_passed++;
    checks_total++; if (if_rdata !== 32'h0) $display("[TB] FAIL tmo_rdata got=%h exp=0", if_rdata); else checks_passed++;
    checks_total++; if (err !== 1'b1) $display("[TB] FAIL tmo_err_set got=%0b exp=1", err); else checks_passed++;
    if_req = 1'b0; never_ack = 1'b0; fixed_lat = 0;
    tick;
    dm_we = 1'b0; dm_addr = 32'h200; dm_req = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick;
      if (dm_ack) got = 1'b1;
    end
    checks_total++; if (!got || dm_rdata !== ref_read(32'h200)) $display("[TB] FAIL tmo_after_load got=%0b/%h exp=1/%h", got, dm_rdata, ref_read(32'h200)); else checks_passed++;
    checks_total++; if (err !== 1'b1) $display("[TB] FAIL tmo_err_sticky got=%0b exp=1", err); else checks_passed++;
    dm_req = 1'b0;
    tick;
    resetn = 1'b0;
    tick;
    resetn = 1'b1;
    checks_total++; if (err !== 1'b0) $display("[TB] FAIL tmo_err_cleared got=%0b exp=0", err); else checks_passed++;
  endtask

  task automatic test_reset_mid_data;
    never_ack = 1'b1;
    tick;
    dm_we = 1'b0; dm_addr = 32'h1C; dm_req = 1'b1;
    tick;
    checks_total++; if (mem_req !== 1'b1) $display("[TB] FAIL rmd_grant got=%0b exp=1", mem_req); else checks_passed++;
    tick;
    resetn = 1'b0;
    tick;
    checks_total++; if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b0, 1'b0, 32'h0, 32'h0}) $display("[TB] FAIL rmd_mem_reset got=%b/%b/%h/%h exp=0/0/0/0", mem_req, mem_we, mem_addr, mem_wdata); else checks_passed++;
    checks_total++; if ({dm_ack, if_ack, err} !== 3'b000) $display("[TB] FAIL rmd_flags got=%b exp=000", {dm_ack, if_ack, err}); else checks_passed++;
    checks_total++; if ({if_rdata, dm_rdata} !== 64'h0) $display("[TB] FAIL rmd_rdata got=%h/%h exp=0/0", if_rdata, dm_rdata); else checks_passed++;
    resetn = 1'b1; never_ack = 1'b0; fixed_lat = 0;
    tick;
    checks_total++; if ({mem_req, dm_ack, mem_addr} !== {1'b1, 1'b0, 32'h1C}) $display("[TB] FAIL rmd_regrant got=%b/%b/%h exp=1/0/1c", mem_req, dm_ack, mem_addr); else checks_passed++;
    tick;
    checks_total++; if (dm_ack !== 1'b1 || dm_rdata !== ref_read(32'h1C)) $display("[TB] FAIL rmd_ack got=%0b/%h exp=1/%h", dm_ack, dm_rdata, ref_read(32'h1C)); else checks_passed++;
    dm_req = 1'b0;
    tick;
  endtask

  task automatic if_driver(input int n);
    int  gap;
    bit  got;
    for (int t = 0; t < n; t++) begin
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        tick;
        checks_total++; if (if_ack !== 1'b0) $display("[TB] FAIL rand_if_spurious got=%0b exp=0", if_ack); else checks_passed++;
      end
      if_addr = 32'($urandom_range(0, 15)) << 2;
      if_req  = 1'b1;
      got = 1'b0;
      for (int c = 0; c < 40 && !got; c++) begin
        tick;
        if (if_ack) got = 1'b1;
      end
      checks_total++; if (!got || if_rdata !== ref_read(if_addr)) $display("[TB] FAIL rand_if_%0d got=%0b/%h exp=1/%h", t, got, if_rdata, ref_read(if_addr)); else checks_passed++;
      if_req = 1'b0;
    end
  endtask

  task automatic dm_driver(input int n);
    int          gap;
    bit          got;
    logic [31:0] exp_data;
    for (int t = 0; t < n; t++) begin
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        tick;
        checks_total++; if (dm_ack !== 1'b0) $display("[TB] FAIL rand_dm_spurious got=%0b exp=0", dm_ack); else checks_passed++;
      end
      dm_addr  = 32'($urandom_range(0, 15)) << 2;
      dm_we    = 1'($urandom_range(0, 1));
      dm_wdata = $urandom;
      dm_req   = 1'b1;
      got = 1'b0;
      for (int c = 0; c < 40 && !got; c++) begin
        tick;
        if (dm_ack) got = 1'b1;
      end
      exp_data = dm_we ? 32'h0 : ref_read(dm_addr);
      checks_total++; if (!got || dm_rdata !== exp_data) $display("[TB] FAIL rand_dm_%0d got=%0b/%h exp=1/%h", t, got, dm_rdata, exp_data); else checks_passed++;
      if (got && dm_we) ref_mem[dm_addr] = dm_wdata;
      dm_req = 1'b0;
    end
  endtask

  task automatic test_random;
    do_reset;
    inject_idle = 1'b1;
    tick;
    fork
      if_driver(20);
      dm_driver(20);
    join
    inject_idle = 1'b0;
    tick;
  endtask

  initial begin
    test_reset;
    test_single_fetch;
    test_simultaneous;
    test_store;
    test_contention;
    test_timeout;
    test_reset_mid_data;
    test_random;
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

  // Hard stop in case a scenario wedges despite its own bounds.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=running exp=finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/pipe_mem_arb.md
# pipe_mem_arb

Arbiter and sequencer that shares one unified single-port memory between the pipeline's instruction-fetch stage and its data-memory stage. Sits between the IF/MEM stages and the memory. Grants one transaction at a time, holds memory attributes stable until the memory acknowledges, and returns per-requester read data and acknowledges. Generates stall signals for the pipeline and flags memories that never respond.

## Interface
- AW, 32, address width
- DW, 32, data width
- TMO, 64, max cycles mem_req may stay high without mem_ack (≥2)
- clock  in  1  rising-edge clock
- resetn  in  1  reset; one clock, synchronous, active-low
- if_req  in  1  fetch request; held until if_ack
- if_addr  in  AW  fetch address
- if_rdata  out  DW  fetched word; valid while if_ack=1
- if_ack  out  1  one-cycle fetch completion pulse
- dm_req  in  1  data request; held until dm_ack
- dm_we  in  1  1=store, 0=load
- dm_addr  in  AW  data address
- dm_wdata  in  DW  store data
- dm_rdata  out  DW  load data; valid while dm_ack=1
- dm_ack  out  1  one-cycle data completion pulse
- mem_req  out  1  memory request, registered
- mem_we  out  1  memory write enable, registered
- mem_addr  out  AW  memory address, registered
- mem_wdata  out  DW  memory write data, registered
- mem_rdata  in  DW  memory read data, valid with mem_ack
- mem_ack  in  1  memory completion, one cycle
- stall_if  out  1  if_req & ~if_ack (combinational)
- stall_dm  out  1  dm_req & ~dm_ack (combinational)
- err  out  1  sticky timeout flag

## Operation
- States: IDLE, FETCH, DATA. Internal last-grant flag `last` (FETCH/DATA) and timeout counter `cnt` (width clog2(TMO)+1).
- Eligibility in IDLE: if_elig = if_req & ~if_ack; dm_elig = dm_req & ~dm_ack. This masks a request still high in the cycle its ack is shown.
- Arbitration in IDLE:
  - only dm_elig: DATA
  - only if_elig: FETCH
  - both: DATA if last=FETCH, else FETCH (round-robin)
  - neither: stay IDLE
- On grant, the same edge loads mem_req=1, mem_addr/mem_we/mem_wdata from the winner, and last=winner. FETCH forces mem_we=0 and mem_wdata=0. cnt=0.
- In FETCH/DATA, mem_* hold constant; cnt increments each cycle without mem_ack.
- mem_ack in FETCH/DATA, at the next edge:
  - mem_req=0, mem_we=0
  - state=IDLE
  - owner's rdata register loads mem_rdata; for a store, dm_rdata loads 0
  - owner's ack=1 for exactly one cycle
- Timeout: in FETCH/DATA with cnt=TMO-1 and mem_ack=0, the next edge acts like completion with rdata=0 and sets err=1. err clears only on reset.
- mem_ack while IDLE is ignored.
- A requester dropping req mid-transaction does not abort it. The store still completes and the ack still pulses.
- if_rdata/dm_rdata hold their last value between acks. Requesters sample only when ack=1.

## Timing
- Reset (resetn=0 at an edge):
  - state=IDLE, last=FETCH (data favoured first), cnt=0
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0
  - if_ack=0, dm_ack=0, if_rdata=0, dm_rdata=0, err=0
  - Reset mid-transaction abandons it: mem_req falls at that edge and no ack is produced.
- Grant decided in cycle T; mem_req=1 from T+1.
- mem_ack may arrive in T+1 (zero wait) or any later cycle T+1+k. The requester's ack is high in T+2+k.
- The ack cycle is also an IDLE arbitration cycle. The next mem_req can rise at T+3+k.
- Minimum 3 cycles per transaction; back-to-back alternation is fair under continuous contention.
- stall_* are combinational from req and the registered ack. They fall in the ack cycle.

## Test plan
- Single fetch: if_req=1, if_addr=0x100, memory acks 2 cycles after mem_req with 0x2010FFFF. Expect: mem_req high 3 cycles, mem_we=0, if_ack for one cycle with if_rdata=0x2010FFFF, stall_if low in that cycle.
- Simultaneous requests after reset: if_req and dm_req (load 0x200) both rise, zero-wait memory. Expect: DATA granted first, then FETCH. mem_req rises at T+1 and T+3; dm_ack at T+2, if_ack at T+4.
- Store with held req: dm_we=1, addr 0x40, wdata 0xDEADBEEF. Expect: mem_we=1 and mem_wdata=0xDEADBEEF stable until mem_ack, dm_ack one cycle, dm_rdata=0, and no second transaction while dm_req stays high in the ack cycle.
- Continuous contention, 6 transactions: grants alternate D,F,D,F,D,F. mem_ack in IDLE is injected and produces no effect.
- Timeout with TMO=4, memory never acks: mem_req high exactly 4 cycles, then if_ack with if_rdata=0 and err=1, which stays 1 through later successful transactions until resetn=0.
- Reset mid-DATA: resetn=0 for one cycle while mem_req=1. Expect: all outputs at reset values next cycle, no dm_ack, and a fresh DATA grant once resetn=1 with dm_req still high.
